// File: rtl/rvh_l1d_ptw_req_arb.sv
// rvh_l1d_ptw_req_arb: one-walk-at-a-time PTW front end to the L1D load pipe with replay and held response
module rvh_l1d_ptw_req_arb #(
  parameter int PTW_ID_W     = 1,
  parameter int PADDR_W      = 56,
  parameter int DATA_W       = 64,
  parameter int REPLAY_CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ptw_req_vld_i,
  input  logic [PTW_ID_W-1:0]     ptw_req_id_i,
  input  logic [PADDR_W-1:0]      ptw_req_paddr_i,
  output logic                    ptw_req_rdy_o,
  output logic                    walk_alloc_vld_o,
  output logic [PTW_ID_W-1:0]     walk_alloc_id_o,
  output logic [PADDR_W-1:0]      walk_alloc_paddr_o,
  input  logic                    replay_vld_i,
  input  logic [PTW_ID_W-1:0]     replay_id_i,
  input  logic [PADDR_W-1:0]      replay_paddr_i,
  output logic                    replay_rdy_o,
  output logic                    l1d_req_vld_o,
  output logic [PTW_ID_W-1:0]     l1d_req_id_o,
  output logic [PADDR_W-1:0]      l1d_req_paddr_o,
  input  logic                    l1d_req_rdy_i,
  input  logic                    l1d_resp_vld_i,
  input  logic [PTW_ID_W-1:0]     l1d_resp_id_i,
  input  logic [DATA_W-1:0]       l1d_resp_data_i,
  output logic                    ptw_resp_vld_o,
  output logic [PTW_ID_W-1:0]     ptw_resp_id_o,
  output logic [DATA_W-1:0]       ptw_resp_data_o,
  input  logic                    ptw_resp_rdy_i,
  output logic                    walk_done_o,
  output logic [REPLAY_CNT_W-1:0] replay_cnt_o,
  output logic                    busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  state_e                  state, state_nxt;
  logic [PTW_ID_W-1:0]     id_q;
  logic [PADDR_W-1:0]      paddr_q;
  logic [DATA_W-1:0]       data_q;
  logic [REPLAY_CNT_W-1:0] cnt_q;
  logic                    alloc_q;
  logic                    accept, replay, resp_hit;
  assign accept   = (state == IDLE) & ptw_req_vld_i;
  assign replay   = (state == WAIT) & replay_vld_i;
  assign resp_hit = (state == WAIT) & l1d_resp_vld_i & (l1d_resp_id_i == id_q);
  assign ptw_req_rdy_o      = state == IDLE;
  assign replay_rdy_o       = state == WAIT;
  assign l1d_req_vld_o      = state == REQ;
  assign ptw_resp_vld_o     = state == RESP;
  assign walk_done_o        = (state == RESP) & ptw_resp_rdy_i;
  assign busy_o             = state != IDLE;
  assign walk_alloc_vld_o   = alloc_q;
  assign walk_alloc_id_o    = id_q;
  assign walk_alloc_paddr_o = paddr_q;
  assign l1d_req_id_o       = id_q;
  assign l1d_req_paddr_o    = paddr_q;
  assign ptw_resp_id_o      = id_q;
  assign ptw_resp_data_o    = data_q;
  assign replay_cnt_o       = cnt_q;
  // a replay takes priority over a same-cycle matching response
  always_comb begin
    state_nxt = accept                            ? REQ  :
                (state == REQ) && l1d_req_rdy_i   ? WAIT :
                replay                            ? REQ  :
                resp_hit                          ? RESP :
                walk_done_o                       ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      id_q    <= '0;
      paddr_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      alloc_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      alloc_q <= accept;
      if (accept) begin
        id_q    <= ptw_req_id_i;
        paddr_q <= ptw_req_paddr_i;
        cnt_q   <= '0;
      end
      if (replay) begin
        paddr_q <= replay_paddr_i;
        cnt_q   <= &cnt_q ? cnt_q : cnt_q + 1'b1;
      end
      if (resp_hit && !replay) data_q <= l1d_resp_data_i;
    end
  end
  a_replay_id: assert property (@(posedge clk) disable iff (!rst)
    replay |-> replay_id_i == id_q);
  a_l1d_req_stable: assert property (@(posedge clk) disable iff (!rst)
    l1d_req_vld_o && !l1d_req_rdy_i |=> $stable(l1d_req_id_o) && $stable(l1d_req_paddr_o));
  a_ptw_resp_stable: assert property (@(posedge clk) disable iff (!rst)
    ptw_resp_vld_o && !ptw_resp_rdy_i |=> $stable(ptw_resp_id_o) && $stable(ptw_resp_data_o));
  c_replay_drops_resp: cover property (@(posedge clk) disable iff (!rst) replay && resp_hit);
endmodule

// File: tb/tb_rvh_l1d_ptw_req_arb.sv
// tb_rvh_l1d_ptw_req_arb: directed self-checking bench for the PTW request arbiter
module tb_rvh_l1d_ptw_req_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        ptw_req_vld_i;
  logic [0:0]  ptw_req_id_i;
  logic [55:0] ptw_req_paddr_i;
  logic        ptw_req_rdy_o;
  logic        walk_alloc_vld_o;
  logic [0:0]  walk_alloc_id_o;
  logic [55:0] walk_alloc_paddr_o;
  logic        replay_vld_i;
  logic [0:0]  replay_id_i;
  logic [55:0] replay_paddr_i;
  logic        replay_rdy_o;
  logic        l1d_req_vld_o;
  logic [0:0]  l1d_req_id_o;
  logic [55:0] l1d_req_paddr_o;
  logic        l1d_req_rdy_i;
  logic        l1d_resp_vld_i;
  logic [0:0]  l1d_resp_id_i;
  logic [63:0] l1d_resp_data_i;
  logic        ptw_resp_vld_o;
  logic [0:0]  ptw_resp_id_o;
  logic [63:0] ptw_resp_data_o;
  logic        ptw_resp_rdy_i;
  logic        walk_done_o;
  logic [3:0]  replay_cnt_o;
  logic        busy_o;
  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  rvh_l1d_ptw_req_arb dut (
    .clk(clk), .rst(rst),
    .ptw_req_vld_i(ptw_req_vld_i), .ptw_req_id_i(ptw_req_id_i), .ptw_req_paddr_i(ptw_req_paddr_i),
    .ptw_req_rdy_o(ptw_req_rdy_o),
    .walk_alloc_vld_o(walk_alloc_vld_o), .walk_alloc_id_o(walk_alloc_id_o),
    .walk_alloc_paddr_o(walk_alloc_paddr_o),
    .replay_vld_i(replay_vld_i), .replay_id_i(replay_id_i), .replay_paddr_i(replay_paddr_i),
    .replay_rdy_o(replay_rdy_o),
    .l1d_req_vld_o(l1d_req_vld_o), .l1d_req_id_o(l1d_req_id_o), .l1d_req_paddr_o(l1d_req_paddr_o),
    .l1d_req_rdy_i(l1d_req_rdy_i),
    .l1d_resp_vld_i(l1d_resp_vld_i), .l1d_resp_id_i(l1d_resp_id_i), .l1d_resp_data_i(l1d_resp_data_i),
    .ptw_resp_vld_o(ptw_resp_vld_o), .ptw_resp_id_o(ptw_resp_id_o), .ptw_resp_data_o(ptw_resp_data_o),
    .ptw_resp_rdy_i(ptw_resp_rdy_i),
    .walk_done_o(walk_done_o), .replay_cnt_o(replay_cnt_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (walk_done_o) done_cnt <= done_cnt + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    rst = 1'b0;
    ptw_req_vld_i = 0; ptw_req_id_i = 0; ptw_req_paddr_i = '0;
    replay_vld_i = 0; replay_id_i = 0; replay_paddr_i = '0;
    l1d_req_rdy_i = 0; l1d_resp_vld_i = 0; l1d_resp_id_i = 0; l1d_resp_data_i = '0;
    ptw_resp_rdy_i = 0;
    #3;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_req_rdy", 64'(ptw_req_rdy_o), 64'd1);
    chk("rst_l1d_vld", 64'(l1d_req_vld_o), 64'd0);
    chk("rst_resp_vld", 64'(ptw_resp_vld_o), 64'd0);
    chk("rst_alloc_vld", 64'(walk_alloc_vld_o), 64'd0);
    chk("rst_cnt", 64'(replay_cnt_o), 64'd0);
    rst = 1'b1;
    tick();
    // basic walk
    ptw_req_vld_i = 1; ptw_req_id_i = 1; ptw_req_paddr_i = 56'h8000_1000;
    l1d_req_rdy_i = 1; ptw_resp_rdy_i = 1;
    tick();
    ptw_req_vld_i = 0;
    chk("b_alloc_vld", 64'(walk_alloc_vld_o), 64'd1);
    chk("b_alloc_id", 64'(walk_alloc_id_o), 64'd1);
    chk("b_alloc_paddr", 64'(walk_alloc_paddr_o), 64'h8000_1000);
    chk("b_l1d_vld", 64'(l1d_req_vld_o), 64'd1);
    chk("b_l1d_id", 64'(l1d_req_id_o), 64'd1);
    chk("b_l1d_paddr", 64'(l1d_req_paddr_o), 64'h8000_1000);
    chk("b_req_rdy", 64'(ptw_req_rdy_o), 64'd0);
    tick();
    chk("b_alloc_pulse", 64'(walk_alloc_vld_o), 64'd0);
    chk("b_l1d_done", 64'(l1d_req_vld_o), 64'd0);
    chk("b_wait_rdy", 64'(replay_rdy_o), 64'd1);
    tick();
    tick();
    l1d_resp_vld_i = 1; l1d_resp_id_i = 1; l1d_resp_data_i = 64'hDEAD_BEEF;
    tick();
    l1d_resp_vld_i = 0;
    chk("b_resp_vld", 64'(ptw_resp_vld_o), 64'd1);
    chk("b_resp_id", 64'(ptw_resp_id_o), 64'd1);
    chk("b_resp_data", ptw_resp_data_o, 64'hDEAD_BEEF);
    chk("b_done", 64'(walk_done_o), 64'd1);
    tick();
    chk("b_done_pulse", 64'(walk_done_o), 64'd0);
    chk("b_busy", 64'(busy_o), 64'd0);
    chk("b_done_cnt", 64'(done_cnt), 64'd1);
    // backpressure on both sides
    l1d_req_rdy_i = 0; ptw_resp_rdy_i = 0;
    ptw_req_vld_i = 1; ptw_req_id_i = 0; ptw_req_paddr_i = 56'h12_3456_7000;
    tick();
    ptw_req_vld_i = 0; ptw_req_paddr_i = 56'hFF_FFFF_F000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_l1d_vld", 64'(l1d_req_vld_o), 64'd1);
      chk("bp_l1d_paddr", 64'(l1d_req_paddr_o), 64'h12_3456_7000);
      chk("bp_req_rdy", 64'(ptw_req_rdy_o), 64'd0);
      tick();
    end
    l1d_req_rdy_i = 1;
    tick();
    l1d_resp_vld_i = 1; l1d_resp_id_i = 0; l1d_resp_data_i = 64'h1122_3344_5566_7788;
    tick();
    l1d_resp_vld_i = 0; l1d_resp_data_i = '0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_resp_vld", 64'(ptw_resp_vld_o), 64'd1);
      chk("bp_resp_data", ptw_resp_data_o, 64'h1122_3344_5566_7788);
      chk("bp_req_rdy2", 64'(ptw_req_rdy_o), 64'd0);
      chk("bp_no_done", 64'(walk_done_o), 64'd0);
      tick();
    end
    ptw_resp_rdy_i = 1;
    #1;
    chk("bp_done", 64'(walk_done_o), 64'd1);
    tick();
    chk("bp_busy", 64'(busy_o), 64'd0);
    chk("bp_done_cnt", 64'(done_cnt), 64'd2);
    // single replay
    ptw_req_vld_i = 1; ptw_req_id_i = 1; ptw_req_paddr_i = 56'h8000_2000;
    tick();
    ptw_req_vld_i = 0;
    tick();
    chk("r_wait_rdy", 64'(replay_rdy_o), 64'd1);
    replay_vld_i = 1; replay_id_i = 1; replay_paddr_i = 56'h8000_1000;
    tick();
    replay_vld_i = 0;
    chk("r_l1d_vld", 64'(l1d_req_vld_o), 64'd1);
    chk("r_l1d_paddr", 64'(l1d_req_paddr_o), 64'h8000_1000);
    chk("r_cnt", 64'(replay_cnt_o), 64'd1);
    chk("r_rdy_req", 64'(replay_rdy_o), 64'd0);
    tick();
    l1d_resp_vld_i = 1; l1d_resp_id_i = 1; l1d_resp_data_i = 64'h0000_0000_CAFE_F00D;
    tick();
    l1d_resp_vld_i = 0;
    chk("r_resp_data", ptw_resp_data_o, 64'h0000_0000_CAFE_F00D);
    tick();
    chk("r_done_cnt", 64'(done_cnt), 64'd3);
    chk("r_busy", 64'(busy_o), 64'd0);
    // saturation of the replay counter
    ptw_req_vld_i = 1; ptw_req_id_i = 1; ptw_req_paddr_i = 56'h9000_0000;
    tick();
    ptw_req_vld_i = 0;
    chk("s_cnt_clear", 64'(replay_cnt_o), 64'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      replay_vld_i = 1; replay_id_i = 1; replay_paddr_i = 56'h9000_0000 + 56'(i);
      tick();
      replay_vld_i = 0;
      if (i == 2) chk("s_cnt3", 64'(replay_cnt_o), 64'd3);
      tick();
    end
    chk("s_cnt_sat", 64'(replay_cnt_o), 64'd15);
    chk("s_wait", 64'(replay_rdy_o), 64'd1);
    chk("s_last_paddr", 64'(l1d_req_paddr_o), 64'h9000_0013);
    // replay collides with a matching response: replay wins
    replay_vld_i = 1; replay_paddr_i = 56'h9000_0100;
    l1d_resp_vld_i = 1; l1d_resp_id_i = 1; l1d_resp_data_i = 64'h5555_AAAA_5555_AAAA;
    tick();
    replay_vld_i = 0; l1d_resp_vld_i = 0;
    chk("c_req", 64'(l1d_req_vld_o), 64'd1);
    chk("c_no_resp", 64'(ptw_resp_vld_o), 64'd0);
    chk("c_paddr", 64'(l1d_req_paddr_o), 64'h9000_0100);
    chk("c_cnt", 64'(replay_cnt_o), 64'd15);
    tick();
    // stray response id is ignored
    l1d_resp_vld_i = 1; l1d_resp_id_i = 0; l1d_resp_data_i = 64'h0BAD;
    tick();
    l1d_resp_vld_i = 0;
    chk("st_wait", 64'(replay_rdy_o), 64'd1);
    chk("st_no_resp", 64'(ptw_resp_vld_o), 64'd0);
    ptw_resp_rdy_i = 0;
    l1d_resp_vld_i = 1; l1d_resp_id_i = 1; l1d_resp_data_i = 64'h600D;
    tick();
    l1d_resp_vld_i = 0;
    chk("st_resp_vld", 64'(ptw_resp_vld_o), 64'd1);
    chk("st_resp_data", ptw_resp_data_o, 64'h600D);
    // asynchronous reset while holding the response
    rst = 1'b0;
    ptw_resp_rdy_i = 1;
    #1;
    chk("ar_resp_vld", 64'(ptw_resp_vld_o), 64'd0);
    chk("ar_l1d_vld", 64'(l1d_req_vld_o), 64'd0);
    chk("ar_alloc_vld", 64'(walk_alloc_vld_o), 64'd0);
    chk("ar_done", 64'(walk_done_o), 64'd0);
    chk("ar_busy", 64'(busy_o), 64'd0);
    chk("ar_req_rdy", 64'(ptw_req_rdy_o), 64'd1);
    chk("ar_cnt", 64'(replay_cnt_o), 64'd0);
    chk("ar_data", ptw_resp_data_o, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_done_cnt", 64'(done_cnt), 64'd3);
    chk("ar_idle", 64'(busy_o), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
